life_engine_param: RTL and testbench

Parametrised Game-of-Life compute engine. It owns a double-buffered board and runs one generation per accepted command at one cell per clock. Rules (birth/survive masks) and the edge mode (toroidal wrap or dead border) are selectable at runtime. A combinational read port feeds the VGA pixel path, a write port feeds a cursor editor, and status outputs report generation and live population.

---
 rtl/life_pkg.sv | 22 ++
 rtl/life_lfsr16.sv | 27 ++
 rtl/life_engine_param.sv | 209 ++++++++++++++++++++
 tb/tb_life_engine_param.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/life_pkg.sv
// Shared encodings for the Game-of-Life engine: command opcodes, FSM states
// and the classic Conway rule masks.
package life_pkg;

  typedef enum logic [1:0] {
    OP_STEP      = 2'd0,
    OP_RANDOMIZE = 2'd1,
    OP_CLEAR     = 2'd2,
    OP_NOP       = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_UPDATE,
    ST_SWAP
  } state_e;

  localparam logic [8:0] CONWAY_BIRTH   = 9'b000001000;
  localparam logic [8:0] CONWAY_SURVIVE = 9'b000001100;

endpackage

// File: rtl/life_lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16/14/13/11), shifting left every clock.
// The random bit presented to the board fill is bit 0 of the current state.
module life_lfsr16
  import life_pkg::*;
#(
  parameter logic [15:0] SEED = 16'h0001
) (
  input  logic clk,
  input  logic reset,
  output logic bit_o
);

  logic [15:0] state_q;
  logic [15:0] state_d;

  always_comb begin
    state_d = {state_q[14:0], state_q[15] ^ state_q[13] ^ state_q[12] ^ state_q[10]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= SEED;
    else       state_q <= state_d;
  end

  assign bit_o = state_q[0];

endmodule

// File: rtl/life_engine_param.sv
// Double-buffered Game-of-Life engine: one cell per clock, runtime rules and
// edge mode, combinational display read port and an IDLE-only editor port.
module life_engine_param
  import life_pkg::*;
#(
  parameter int          LOG_W     = 6,
  parameter int          LOG_H     = 6,
  parameter logic [15:0] LFSR_SEED = 16'h0001,
  parameter int          GEN_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  input  logic [1:0]           cmd_op,
  output logic                 cmd_ready,
  input  logic [8:0]           birth_mask,
  input  logic [8:0]           survive_mask,
  input  logic                 wrap_en,
  input  logic [LOG_W-1:0]     rd_x,
  input  logic [LOG_H-1:0]     rd_y,
  output logic                 rd_cell,
  input  logic                 wr_en,
  input  logic [LOG_W-1:0]     wr_x,
  input  logic [LOG_H-1:0]     wr_y,
  input  logic                 wr_data,
  output logic                 busy,
  output logic                 done,
  output logic [GEN_W-1:0]     generation,
  output logic [LOG_W+LOG_H:0] population,
  output logic                 extinct
);

  localparam int IW = LOG_W + LOG_H;
  localparam int N  = 1 << IW;
  localparam int PW = IW + 1;

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [8:0]        birth_q, birth_d;
  logic [8:0]        survive_q, survive_d;
  logic              wrap_q, wrap_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [PW-1:0]     pcnt_q, pcnt_d;
  logic              bank_sel_q, bank_sel_d;
  logic [GEN_W-1:0]  gen_q, gen_d;
  logic [PW-1:0]     pop_q, pop_d;
  logic              done_q, done_d;

  logic [N-1:0]      bank0_q, bank1_q;
  logic [N-1:0]      front_v;
  logic              mem_we, mem_bank, mem_wdata;
  logic [IW-1:0]     mem_idx;

  logic              lfsr_bit;
  logic [LOG_W-1:0]  cur_x;
  logic [LOG_H-1:0]  cur_y;
  logic [LOG_W-1:0]  col [3];
  logic [LOG_H-1:0]  row [3];
  logic              col_ok [3];
  logic              row_ok [3];
  logic [3:0]        nbr_cnt;
  logic              cur_cell, next_cell;

  life_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .bit_o (lfsr_bit)
  );

  assign front_v = bank_sel_q ? bank1_q : bank0_q;
  assign cur_x   = idx_q[LOG_W-1:0];
  assign cur_y   = idx_q[IW-1:LOG_W];

  // Off-board neighbours are masked out via *_ok unless the board is toroidal.
  always_comb begin
    col[0]    = cur_x - LOG_W'(1);
    col[1]    = cur_x;
    col[2]    = cur_x + LOG_W'(1);
    row[0]    = cur_y - LOG_H'(1);
    row[1]    = cur_y;
    row[2]    = cur_y + LOG_H'(1);
    col_ok[0] = wrap_q || (cur_x != '0);
    col_ok[1] = 1'b1;
    col_ok[2] = wrap_q || (cur_x != '1);
    row_ok[0] = wrap_q || (cur_y != '0);
    row_ok[1] = 1'b1;
    row_ok[2] = wrap_q || (cur_y != '1);
    nbr_cnt   = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        if (!(r == 1 && c == 1)) begin
          nbr_cnt = nbr_cnt + 4'(row_ok[r] && col_ok[c] && front_v[{row[r], col[c]}]);
        end
      end
    end
    cur_cell  = front_v[idx_q];
    next_cell = cur_cell ? survive_q[nbr_cnt] : birth_q[nbr_cnt];
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can leave a latch.
    state_d    = state_q;
    op_d       = op_q;
    birth_d    = birth_q;
    survive_d  = survive_q;
    wrap_d     = wrap_q;
    idx_d      = idx_q;
    pcnt_d     = pcnt_q;
    bank_sel_d = bank_sel_q;
    gen_d      = gen_q;
    pop_d      = pop_q;
    done_d     = 1'b0;
    mem_we     = 1'b0;
    mem_bank   = ~bank_sel_q;
    mem_idx    = idx_q;
    mem_wdata  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // The edit lands on this edge, so a command accepted alongside it sees the new value.
        if (wr_en) begin
          mem_we    = 1'b1;
          mem_bank  = bank_sel_q;
          mem_idx   = {wr_y, wr_x};
          mem_wdata = wr_data;
          if (wr_data != front_v[{wr_y, wr_x}]) begin
            pop_d = wr_data ? pop_q + PW'(1) : pop_q - PW'(1);
          end
        end
        if (cmd_valid) begin
          op_d      = op_e'(cmd_op);
          birth_d   = birth_mask;
          survive_d = survive_mask;
          wrap_d    = wrap_en;
          idx_d     = '0;
          pcnt_d    = '0;
          case (op_e'(cmd_op))
            OP_STEP: state_d = ST_UPDATE;
            OP_NOP:  state_d = ST_SWAP;
            default: state_d = ST_FILL;
          endcase
        end
      end
      ST_FILL, ST_UPDATE: begin
        mem_we    = 1'b1;
        mem_wdata = (state_q == ST_UPDATE) ? next_cell : (op_q == OP_RANDOMIZE) && lfsr_bit;
        pcnt_d    = pcnt_q + PW'(mem_wdata);
        idx_d     = idx_q + IW'(1);
        if (idx_q == '1) state_d = ST_SWAP;
      end
      ST_SWAP: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
        if (op_q != OP_NOP) begin
          bank_sel_d = ~bank_sel_q;
          pop_d      = pcnt_q;
          gen_d      = (op_q == OP_STEP) ? gen_q + GEN_W'(1) : '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_FILL;
      op_q       <= OP_RANDOMIZE;
      birth_q    <= CONWAY_BIRTH;
      survive_q  <= CONWAY_SURVIVE;
      wrap_q     <= 1'b1;
      idx_q      <= '0;
      pcnt_q     <= '0;
      bank_sel_q <= 1'b0;
      gen_q      <= '0;
      pop_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      birth_q    <= birth_d;
      survive_q  <= survive_d;
      wrap_q     <= wrap_d;
      idx_q      <= idx_d;
      pcnt_q     <= pcnt_d;
      bank_sel_q <= bank_sel_d;
      gen_q      <= gen_d;
      pop_q      <= pop_d;
      done_q     <= done_d;
    end
  end

  // NOTE: board storage is deliberately not reset; every command rewrites the whole back bank.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      if (mem_bank) bank1_q[mem_idx] <= mem_wdata;
      else          bank0_q[mem_idx] <= mem_wdata;
    end
  end

  assign cmd_ready  = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign done       = done_q;
  assign generation = gen_q;
  assign population = pop_q;
  assign extinct    = (pop_q == '0);
  assign rd_cell    = front_v[{rd_y, rd_x}];

endmodule

// File: tb/tb_life_engine_param.sv
// Scoreboard bench for life_engine_param on an 8x8 board: stimulus pushes the
// expected result of each command, a done-driven monitor pops and compares.
module tb_life_engine_param;
  import life_pkg::*;

  localparam int N   = 64;
  localparam int LAT = N + 1;

  typedef struct {
    logic [63:0] board;
    int          gen;
    int          lat;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_op = 2'd0;
  logic        cmd_ready;
  logic [8:0]  birth_mask = CONWAY_BIRTH;
  logic [8:0]  survive_mask = CONWAY_SURVIVE;
  logic        wrap_en = 1'b1;
  logic [2:0]  rd_x, rd_y;
  logic        rd_cell;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_x = 3'd0, wr_y = 3'd0;
  logic        wr_data = 1'b0;
  logic        busy, done, extinct;
  logic [15:0] generation;
  logic [6:0]  population;

  logic [2:0]  stim_rx = 3'd0, stim_ry = 3'd0, mon_rx = 3'd0, mon_ry = 3'd0;
  logic        scanning = 1'b0;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  int          last_done_cyc = -1;
  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [63:0] mon_board;
  logic [63:0] bd, rb, g4, blink_v, blink_h;
  int          gen, acc;

  assign rd_x = scanning ? mon_rx : stim_rx;
  assign rd_y = scanning ? mon_ry : stim_ry;

  life_engine_param #(
    .LOG_W(3), .LOG_H(3), .LFSR_SEED(16'h0001), .GEN_W(16)
  ) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
    .cmd_ready(cmd_ready), .birth_mask(birth_mask), .survive_mask(survive_mask),
    .wrap_en(wrap_en), .rd_x(rd_x), .rd_y(rd_y), .rd_cell(rd_cell),
    .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
    .busy(busy), .done(done), .generation(generation),
    .population(population), .extinct(extinct)
  );

  always #100 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] bit_at(input int x, input int y);
    return 64'(1) << (y * 8 + x);
  endfunction

  function automatic logic [63:0] rand_board();
    logic [15:0] l;
    logic [63:0] r;
    l = 16'h0001;
    r = '0;
    for (int i = 0; i < N; i++) begin
      r[i] = l[0];
      l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    end
    return r;
  endfunction

  function automatic logic [63:0] life_step(input logic [63:0] b, input logic [8:0] bm,
                                            input logic [8:0] sm, input logic w);
    logic [63:0] r;
    r = '0;
    for (int y = 0; y < 8; y++) begin
      for (int x = 0; x < 8; x++) begin
        int n;
        n = 0;
        for (int dy = -1; dy <= 1; dy++) begin
          for (int dx = -1; dx <= 1; dx++) begin
            int xx, yy;
            xx = x + dx;
            yy = y + dy;
            if (dx == 0 && dy == 0) continue;
            if (w) begin
              xx = (xx + 8) % 8;
              yy = (yy + 8) % 8;
            end else if (xx < 0 || xx > 7 || yy < 0 || yy > 7) begin
              continue;
            end
            n += int'(b[yy * 8 + xx]);
          end
        end
        r[y * 8 + x] = b[y * 8 + x] ? sm[n] : bm[n];
      end
    end
    return r;
  endfunction

  // Monitor: every done pulse must match the oldest pending expectation.
  initial forever begin
    @(negedge clk);
    if (!reset && done) begin
      last_done_cyc = cyc;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: done=1 with no command pending at cycle %0d", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        scanning = 1'b1;
        check("generation", 64'(generation), 64'(mon_e.gen));
        check("population", 64'(population), 64'($countones(mon_e.board)));
        check("extinct", 64'(extinct), 64'(mon_e.board == '0));
        check("latency", 64'(cyc - mon_e.acc), 64'(mon_e.lat));
        for (int i = 0; i < N; i++) begin
          mon_rx = 3'(i);
          mon_ry = 3'(i >> 3);
          #1;
          mon_board[i] = rd_cell;
        end
        scanning = 1'b0;
        check("board", mon_board, mon_e.board);
      end
    end
  end

  task automatic wait_idle();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || scanning) && k < 400) begin
      @(negedge clk);
      k++;
    end
    if (k >= 400) begin
      n_cmp++;
      n_err++;
      $display("FAIL done_timeout: %0d results still pending, expected 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [8:0] b, input logic [8:0] s,
                       input logic w, input logic [63:0] eb, input int eg, output int a);
    int k;
    k = 0;
    cmd_op = op;
    birth_mask = b;
    survive_mask = s;
    wrap_en = w;
    cmd_valid = 1'b1;
    @(negedge clk);
    while (!cmd_ready && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (!cmd_ready) begin
      cmd_valid = 1'b0;
      a = -1;
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout: cmd_ready=%0b after %0d cycles, expected 1", cmd_ready, k);
      return;
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    a = cyc;
    exp_q.push_back('{board: eb, gen: eg, lat: (op == OP_NOP) ? 1 : LAT, acc: a});
  endtask

  task automatic cmd(input logic [1:0] op, input logic [8:0] b, input logic [8:0] s,
                     input logic w, input logic [63:0] eb, input int eg);
    int a;
    issue(op, b, s, w, eb, eg, a);
    wait_idle();
  endtask

  task automatic wr(input int x, input int y, input logic d);
    wr_x = 3'(x);
    wr_y = 3'(y);
    wr_data = d;
    wr_en = 1'b1;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic put_glider();
    wr(7, 6, 1'b1); wr(0, 7, 1'b1); wr(6, 0, 1'b1); wr(7, 0, 1'b1); wr(0, 0, 1'b1);
    bd = bit_at(7, 6) | bit_at(0, 7) | bit_at(6, 0) | bit_at(7, 0) | bit_at(0, 0);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'(1));
    check({tag, "_ready"}, 64'(cmd_ready), 64'(0));
    check({tag, "_done"}, 64'(done), 64'(0));
    check({tag, "_gen"}, 64'(generation), 64'(0));
    check({tag, "_pop"}, 64'(population), 64'(0));
  endtask

  initial begin
    #50000000;
    $display("FAIL watchdog: time limit reached after %0d comparisons", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    rb      = rand_board();
    blink_v = bit_at(3, 2) | bit_at(3, 3) | bit_at(3, 4);
    blink_h = bit_at(2, 3) | bit_at(3, 3) | bit_at(4, 3);
    g4      = bit_at(0, 7) | bit_at(1, 0) | bit_at(7, 1) | bit_at(0, 1) | bit_at(1, 1);

    // Power-on: reset, then the randomized board after 65 cycles.
    #1 reset = 1'b1;
    #1 reset_checks("rst");
    check("rst_extinct", 64'(extinct), 64'(1));
    @(negedge clk);
    @(negedge clk);
    exp_q.push_back('{board: rb, gen: 0, lat: LAT, acc: cyc});
    reset = 1'b0;
    wait_idle();

    // Blinker oscillation with Conway rules.
    cmd(OP_CLEAR, CONWAY_BIRTH, CONWAY_SURVIVE, 1'b1, '0, 0);
    wr(3, 2, 1'b1); wr(3, 3, 1'b1); wr(3, 4, 1'b1);
    check("edit_pop", 64'(population), 64'(3));
    wr(3, 3, 1'b1);
    check("edit_same_value_pop", 64'(population), 64'(3));
    cmd(OP_STEP, CONWAY_BIRTH, CONWAY_SURVIVE, 1'b1, blink_h, 1);
    cmd(OP_STEP, CONWAY_BIRTH, CONWAY_SURVIVE, 1'b1, blink_v, 2);

    // Glider on a torus: after 4 generations it is shifted by (+1,+1).
    cmd(OP_CLEAR, CONWAY_BIRTH, CONWAY_SURVIVE, 1'b1, '0, 0);
    put_glider();
    for (int g = 1; g <= 3; g++) begin
      bd = life_step(bd, CONWAY_BIRTH, CONWAY_SURVIVE, 1'b1);
      cmd(OP_STEP, CONWAY_BIRTH, CONWAY_SURVIVE, 1'b1, bd, g);
    end
    cmd(OP_STEP, CONWAY_BIRTH, CONWAY_SURVIVE, 1'b1, g4, 4);

    // Same glider with a dead border.
    cmd(OP_CLEAR, CONWAY_BIRTH, CONWAY_SURVIVE, 1'b0, '0, 0);
    put_glider();
    for (int g = 1; g <= 4; g++) begin
      bd = life_step(bd, CONWAY_BIRTH, CONWAY_SURVIVE, 1'b0);
      cmd(OP_STEP, CONWAY_BIRTH, CONWAY_SURVIVE, 1'b0, bd, g);
    end

    // All-zero rules latched; masks changed while busy must not matter.
    wr(3, 2, 1'b1); wr(3, 3, 1'b1); wr(3, 4, 1'b1);
    issue(OP_STEP, 9'd0, 9'd0, 1'b1, '0, 5, acc);
    birth_mask = CONWAY_BIRTH;
    survive_mask = CONWAY_SURVIVE;
    wrap_en = 1'b0;
    wait_idle();

    // Held command during a step; editor write while busy is ignored.
    wr(3, 2, 1'b1); wr(3, 3, 1'b1); wr(3, 4, 1'b1);
    bd = blink_v;
    issue(OP_STEP, CONWAY_BIRTH, CONWAY_SURVIVE, 1'b1, blink_h, 6, acc);
    stim_rx = 3'd3;
    stim_ry = 3'd3;
    wr(3, 3, 1'b0);
    check("busy_write_rd_cell", 64'(rd_cell), 64'(1));
    check("busy_write_pop", 64'(population), 64'(3));
    issue(OP_STEP, CONWAY_BIRTH, CONWAY_SURVIVE, 1'b1, blink_v, 7, acc);
    check("accept_first_ready", 64'(acc), 64'(last_done_cyc + 1));
    wait_idle();

    // Reserved op: one-cycle done, nothing changes.
    cmd(OP_NOP, CONWAY_BIRTH, CONWAY_SURVIVE, 1'b1, blink_v, 7);

    // Reset in the middle of a step abandons it and re-randomizes.
    issue(OP_STEP, CONWAY_BIRTH, CONWAY_SURVIVE, 1'b1, blink_h, 8, acc);
    repeat (19) @(posedge clk);
    #2;
    reset = 1'b1;
    exp_q.delete();
    #1 reset_checks("midrst");
    @(negedge clk);
    @(negedge clk);
    exp_q.push_back('{board: rb, gen: 0, lat: LAT, acc: cyc});
    reset = 1'b0;
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
